// File: rtl/cnn_pkg.sv
// Shared CNN pooling types and constants.
// Used by the pool/flatten writer and its max-reduction datapath.
package cnn_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      FLUSH,
      DONE
   } pool_state_t;

   localparam int POOL_WINDOW_SIZE = 4;
   localparam int DATA_WIDTH       = 16;

endpackage

// File: rtl/pool_flatten_writer_if.sv
// Conv2 read stream in, flatten BRAM port A out.
// master = stream source / BRAM side, slave = the writer.
interface pool_flatten_writer_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8
);
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  ena_flatten;
   logic                  wea_flatten;
   logic                  addren_flatten;
   logic [ADDR_WIDTH-1:0] addra_flatten;
   logic [DATA_WIDTH-1:0] dina_flatten;

   modport master (
      output in_valid,
      output in_data,
      input  ena_flatten,
      input  wea_flatten,
      input  addren_flatten,
      input  addra_flatten,
      input  dina_flatten
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output ena_flatten,
      output wea_flatten,
      output addren_flatten,
      output addra_flatten,
      output dina_flatten
   );
endinterface

// File: rtl/max4_accum.sv
// Signed max over groups of four words.
// window_complete is high the cycle after the 4th word.
module max4_accum #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         clear,
   input  logic                         in_valid,
   input  logic signed [DATA_WIDTH-1:0] in_data,
   output logic signed [DATA_WIDTH-1:0] max_q,
   output logic                         window_complete
);
   import cnn_pkg::*;

   localparam logic [1:0] LAST_WORD = 2'(POOL_WINDOW_SIZE - 1);

   logic [1:0] word_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         word_q          <= '0;
         max_q           <= '0;
         window_complete <= 1'b0;
      end else if (clear) begin
         word_q          <= '0;
         max_q           <= '0;
         window_complete <= 1'b0;
      end else begin
         window_complete <= in_valid && (word_q == LAST_WORD);
         if (in_valid) begin
            word_q <= word_q + 2'd1;
            // first word seeds the max so all-negative windows work
            if (word_q == 2'd0)
               max_q <= in_data;
            else if (in_data > max_q)
               max_q <= in_data;
         end
      end
   end

endmodule

// File: rtl/pool_flatten_writer.sv
// 2x2 max-pool of the conv2 stream, written in order
// into the flatten BRAM; one frame per start pulse.
module pool_flatten_writer #(
   parameter int DATA_WIDTH             = cnn_pkg::DATA_WIDTH,
   parameter int IN_WIDTH               = 8,
   parameter int IN_HEIGHT              = 8,
   parameter int NUM_CHANNELS           = 1,
   parameter int ADDRESS_LENGTH_FLATTEN = 8
) (
   input  logic clk,
   input  logic rstn,
   input  logic start,
   output logic busy,
   output logic done,
   pool_flatten_writer_if.slave bus
);
   import cnn_pkg::*;

   localparam int AW          = ADDRESS_LENGTH_FLATTEN;
   localparam int NUM_WINDOWS =
      (IN_WIDTH / 2) * (IN_HEIGHT / 2) * NUM_CHANNELS;
   localparam logic [AW-1:0] LAST_WIN = AW'(NUM_WINDOWS - 1);

   pool_state_t state_q, state_d;

   logic [AW-1:0]                win_q;
   logic                         clear;
   logic                         accept;
   logic                         win_done;
   logic                         last_write;
   logic signed [DATA_WIDTH-1:0] max_q;

   assign clear      = (state_q == IDLE) && start;
   assign last_write = win_done && (win_q == LAST_WIN);
   // words behind the final window are dropped
   assign accept     = bus.in_valid && (state_q == ACCUM) && !last_write;

   max4_accum #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_max4 (
      .clk            (clk),
      .rstn           (rstn),
      .clear          (clear),
      .in_valid       (accept),
      .in_data        (bus.in_data),
      .max_q          (max_q),
      .window_complete(win_done)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         win_q   <= '0;
      end else begin
         state_q <= state_d;
         if (clear)
            win_q <= '0;
         else if (bus.wea_flatten)
            win_q <= win_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (start) state_d = ACCUM;
         ACCUM: if (last_write) state_d = FLUSH;
         FLUSH: state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy               = (state_q == ACCUM) || (state_q == FLUSH);
   assign done               = (state_q == DONE);
   assign bus.ena_flatten    = busy;
   assign bus.addren_flatten = busy;
   assign bus.wea_flatten    = (state_q == ACCUM) && win_done;
   assign bus.addra_flatten  = win_q;
   assign bus.dina_flatten   = bus.wea_flatten ? max_q : '0;

endmodule
